// File: rtl/except_ctrl_pkg.sv
// Shared ExcCode constants, mem_exc flag positions and event decode for except_ctrl.
package except_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam int unsigned FLG_IF_ADEL  = 6;
  localparam int unsigned FLG_ID_RI    = 5;
  localparam int unsigned FLG_EX_OV    = 4;
  localparam int unsigned FLG_ID_SYS   = 3;
  localparam int unsigned FLG_ID_BP    = 2;
  localparam int unsigned FLG_MEM_ADEL = 1;
  localparam int unsigned FLG_MEM_ADES = 0;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic        exc;
    logic        eret;
    logic [4:0]  code;
    logic        bv_we;
    logic [31:0] bv;
  } event_t;

  // First match wins; ERET only survives when nothing else is pending.
  function automatic event_t pick_event(input logic        int_pend,
                                        input logic [6:0]  flags,
                                        input logic        eret,
                                        input logic [31:0] pc,
                                        input logic [31:0] badvaddr);
    event_t ev;
    ev     = '0;
    ev.exc = 1'b1;
    if (int_pend) begin
      ev.code = EXC_INT;
    end else if (flags[FLG_IF_ADEL]) begin
      ev.code  = EXC_ADEL;
      ev.bv_we = 1'b1;
      ev.bv    = pc;
    end else if (flags[FLG_ID_RI]) begin
      ev.code = EXC_RI;
    end else if (flags[FLG_EX_OV]) begin
      ev.code = EXC_OV;
    end else if (flags[FLG_ID_SYS]) begin
      ev.code = EXC_SYS;
    end else if (flags[FLG_ID_BP]) begin
      ev.code = EXC_BP;
    end else if (flags[FLG_MEM_ADEL]) begin
      ev.code  = EXC_ADEL;
      ev.bv_we = 1'b1;
      ev.bv    = badvaddr;
    end else if (flags[FLG_MEM_ADES]) begin
      ev.code  = EXC_ADES;
      ev.bv_we = 1'b1;
      ev.bv    = badvaddr;
    end else begin
      ev.exc  = 1'b0;
      ev.eret = eret;
    end
    return ev;
  endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// Pipeline/CP0 signal bundle for except_ctrl; slave = sequencer side, master = pipeline/CP0 side.
interface except_ctrl_if;
  logic        stall;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_ds;
  logic [6:0]  mem_exc;
  logic        mem_eret;
  logic [31:0] mem_badvaddr;
  logic [5:0]  ext_int;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [1:0]  cause_ip_sw;
  logic [31:0] cp0_epc;
  logic        cmp_we;
  logic [31:0] cmp_wdata;
  logic        cnt_we;
  logic [31:0] cnt_wdata;
  logic        exc_commit;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        exc_bv_we;
  logic        eret_commit;
  logic        flush;
  logic [31:0] new_pc;
  logic        timer_int;
  logic [31:0] count_o;

  modport slave (
    input  stall, mem_valid, mem_pc, mem_in_ds, mem_exc, mem_eret, mem_badvaddr,
    input  ext_int, status_ie, status_exl, status_im, cause_ip_sw, cp0_epc,
    input  cmp_we, cmp_wdata, cnt_we, cnt_wdata,
    output exc_commit, exc_code, exc_epc, exc_bd, exc_badvaddr, exc_bv_we,
    output eret_commit, flush, new_pc, timer_int, count_o
  );

  modport master (
    output stall, mem_valid, mem_pc, mem_in_ds, mem_exc, mem_eret, mem_badvaddr,
    output ext_int, status_ie, status_exl, status_im, cause_ip_sw, cp0_epc,
    output cmp_we, cmp_wdata, cnt_we, cnt_wdata,
    input  exc_commit, exc_code, exc_epc, exc_bd, exc_badvaddr, exc_bv_we,
    input  eret_commit, flush, new_pc, timer_int, count_o
  );
endinterface

// File: rtl/except_ctrl_cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, timer_int latches on match until Compare is written.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_we_i,
  input  logic [31:0] cnt_wdata_i,
  input  logic        cmp_we_i,
  input  logic [31:0] cmp_wdata_i,
  output logic [31:0] count_o,
  output logic        timer_int_o
);
  logic [31:0] count_q, count_d, compare_q;
  logic        tog_q, tint_q, inc;

  always_comb begin
    inc     = 1'b0;
    count_d = count_q;
    if (cnt_we_i) begin
      count_d = cnt_wdata_i;
    end else if (tog_q) begin
      inc     = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      tog_q     <= 1'b0;
      tint_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tog_q   <= cnt_we_i ? 1'b0 : ~tog_q;
      if (cmp_we_i) begin
        compare_q <= cmp_wdata_i;
        tint_q    <= 1'b0;
      end else if (inc && (count_d == compare_q)) begin
        tint_q <= 1'b1;
      end
    end
  end

  assign count_o     = count_q;
  assign timer_int_o = tint_q;
endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: one registered CP0 commit + flush per event, then a drain window.
// Macro EXCEPT_TIMER_EN includes the internal Count/Compare timer (cp0_timer).
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  except_ctrl_if.slave bus
);
  state_e      state_q;
  logic [2:0]  drain_q;
  logic        exc_commit_q, eret_commit_q, flush_q, exc_bd_q, exc_bv_we_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_epc_q, exc_badvaddr_q, new_pc_q;
  logic        timer_int;
  logic [31:0] count_val;
  logic        int_pend, take;
  event_t      ev;

`ifdef EXCEPT_TIMER_EN
  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .cnt_we_i    (bus.cnt_we),
    .cnt_wdata_i (bus.cnt_wdata),
    .cmp_we_i    (bus.cmp_we),
    .cmp_wdata_i (bus.cmp_wdata),
    .count_o     (count_val),
    .timer_int_o (timer_int)
  );
`else
  logic unused_timer_in;
  assign unused_timer_in = ^{bus.cnt_we, bus.cnt_wdata, bus.cmp_we, bus.cmp_wdata};
  assign timer_int       = 1'b0;
  assign count_val       = '0;
`endif

  assign int_pend = (|({bus.ext_int[5] | timer_int, bus.ext_int[4:0], bus.cause_ip_sw}
                       & bus.status_im)) & bus.status_ie & ~bus.status_exl;
  assign ev   = pick_event(int_pend, bus.mem_exc, bus.mem_eret, bus.mem_pc, bus.mem_badvaddr);
  assign take = bus.mem_valid & ~bus.stall & (ev.exc | ev.eret);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      drain_q        <= '0;
      exc_commit_q   <= 1'b0;
      eret_commit_q  <= 1'b0;
      flush_q        <= 1'b0;
      exc_bv_we_q    <= 1'b0;
      exc_bd_q       <= 1'b0;
      exc_code_q     <= '0;
      exc_epc_q      <= '0;
      exc_badvaddr_q <= '0;
      new_pc_q       <= '0;
    end else begin
      exc_commit_q  <= 1'b0;
      eret_commit_q <= 1'b0;
      flush_q       <= 1'b0;
      exc_bv_we_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_q <= ST_COMMIT;
            flush_q <= 1'b1;
            // ERET leaves the exception fields untouched; only the redirect changes.
            if (ev.exc) begin
              exc_commit_q <= 1'b1;
              exc_code_q   <= ev.code;
              exc_epc_q    <= bus.mem_in_ds ? bus.mem_pc - 32'd4 : bus.mem_pc;
              exc_bd_q     <= bus.mem_in_ds;
              exc_bv_we_q  <= ev.bv_we;
              if (ev.bv_we) exc_badvaddr_q <= ev.bv;
              new_pc_q     <= EXC_VECTOR;
            end else begin
              eret_commit_q <= 1'b1;
              new_pc_q      <= bus.cp0_epc;
            end
          end
        end
        ST_COMMIT: begin
          state_q <= ST_DRAIN;
          drain_q <= 3'(DRAIN_CYCLES - 1);
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_q <= ST_IDLE;
          else               drain_q <= drain_q - 3'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.exc_commit   = exc_commit_q;
  assign bus.eret_commit  = eret_commit_q;
  assign bus.flush        = flush_q;
  assign bus.exc_code     = exc_code_q;
  assign bus.exc_epc      = exc_epc_q;
  assign bus.exc_bd       = exc_bd_q;
  assign bus.exc_badvaddr = exc_badvaddr_q;
  assign bus.exc_bv_we    = exc_bv_we_q;
  assign bus.new_pc       = new_pc_q;
  assign bus.timer_int    = timer_int;
  assign bus.count_o      = count_val;
endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed scenarios plus random traffic against a cycle-indexed model.
module tb_except_ctrl;
  localparam int unsigned D   = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  except_ctrl_if bus ();

  except_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: edge index e, earliest edge at which a new event may be sampled.
  int e = 0;
  int free_at = 0;
  logic        x_commit, x_eret, x_flush, x_bd, x_bvwe;
  logic [4:0]  x_code;
  logic [31:0] x_epc, x_bv, x_newpc;
  int          cnt_L = 0;
  logic [31:0] cnt_val, m_cmp;
  logic        m_tint;

  function automatic logic [31:0] m_count();
`ifdef EXCEPT_TIMER_EN
    return cnt_val + 32'((e - cnt_L) / 2);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_edge();
    logic [7:0] ip;
    logic       pend, found, inc;
    int         flag_bit[7] = '{6, 5, 4, 3, 2, 1, 0};
    logic [4:0] flag_code[7] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
    logic       tint_before;
    e++;
    tint_before = m_tint;
    if (rst) begin
      {x_commit, x_eret, x_flush, x_bd, x_bvwe} = '0;
      x_code = '0; x_epc = '0; x_bv = '0; x_newpc = '0;
      free_at = e + 1;
      cnt_val = '0; cnt_L = e; m_cmp = '0; m_tint = 1'b0;
      return;
    end
    x_commit = 1'b0; x_eret = 1'b0; x_flush = 1'b0; x_bvwe = 1'b0;
    if (bus.mem_valid && !bus.stall && e >= free_at) begin
      ip    = {bus.ext_int[5] | tint_before, bus.ext_int[4:0], bus.cause_ip_sw};
      pend  = (|(ip & bus.status_im)) && bus.status_ie && !bus.status_exl;
      found = 1'b0;
      if (pend) begin
        found = 1'b1; x_code = 5'h00;
      end else begin
        for (int i = 0; i < 7; i++) begin
          if (!found && bus.mem_exc[flag_bit[i]]) begin
            found  = 1'b1;
            x_code = flag_code[i];
            if (flag_bit[i] == 6) begin x_bvwe = 1'b1; x_bv = bus.mem_pc; end
            if (flag_bit[i] <= 1) begin x_bvwe = 1'b1; x_bv = bus.mem_badvaddr; end
          end
        end
      end
      if (found) begin
        x_commit = 1'b1; x_flush = 1'b1; x_newpc = VEC;
        x_epc    = bus.mem_in_ds ? bus.mem_pc - 32'd4 : bus.mem_pc;
        x_bd     = bus.mem_in_ds;
        free_at  = e + 2 + int'(D);
      end else if (bus.mem_eret) begin
        x_eret = 1'b1; x_flush = 1'b1; x_newpc = bus.cp0_epc;
        free_at = e + 2 + int'(D);
      end
    end
`ifdef EXCEPT_TIMER_EN
    if (bus.cnt_we) begin
      cnt_val = bus.cnt_wdata; cnt_L = e; inc = 1'b0;
    end else begin
      inc = ((e - cnt_L) % 2 == 0);
    end
    if (bus.cmp_we) begin
      m_cmp = bus.cmp_wdata; m_tint = 1'b0;
    end else if (inc && m_count() == m_cmp) begin
      m_tint = 1'b1;
    end
`else
    inc = 1'b0;
    if (inc) m_tint = 1'b1;
`endif
  endtask

  task automatic compare_all();
    check("exc_commit",   32'(bus.exc_commit),   32'(x_commit));
    check("eret_commit",  32'(bus.eret_commit),  32'(x_eret));
    check("flush",        32'(bus.flush),        32'(x_flush));
    check("new_pc",       bus.new_pc,            x_newpc);
    check("exc_code",     32'(bus.exc_code),     32'(x_code));
    check("exc_epc",      bus.exc_epc,           x_epc);
    check("exc_bd",       32'(bus.exc_bd),       32'(x_bd));
    check("exc_badvaddr", bus.exc_badvaddr,      x_bv);
    check("exc_bv_we",    32'(bus.exc_bv_we),    32'(x_bvwe));
    check("timer_int",    32'(bus.timer_int),    32'(m_tint));
    check("count",        bus.count_o,           m_count());
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    bus.stall = 1'b0; bus.mem_valid = 1'b0; bus.mem_pc = '0; bus.mem_in_ds = 1'b0;
    bus.mem_exc = '0; bus.mem_eret = 1'b0; bus.mem_badvaddr = '0; bus.ext_int = '0;
    bus.status_ie = 1'b0; bus.status_exl = 1'b0; bus.status_im = '0; bus.cause_ip_sw = '0;
    bus.cp0_epc = '0; bus.cmp_we = 1'b0; bus.cmp_wdata = '0; bus.cnt_we = 1'b0; bus.cnt_wdata = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    rst              = ($urandom % 100) == 0;
    bus.stall        = ($urandom % 5) == 0;
    bus.mem_valid    = ($urandom % 4) != 0;
    bus.mem_pc       = $urandom & 32'hFFFF_FFFC;
    bus.mem_in_ds    = $urandom % 2;
    bus.mem_exc      = (($urandom % 3) == 0) ? 7'($urandom) & 7'($urandom) : 7'd0;
    bus.mem_eret     = ($urandom % 5) == 0;
    bus.mem_badvaddr = $urandom;
    bus.ext_int      = (($urandom % 6) == 0) ? 6'($urandom) : 6'd0;
    bus.status_ie    = $urandom % 2;
    bus.status_exl   = $urandom % 2;
    bus.status_im    = 8'($urandom);
    bus.cause_ip_sw  = (($urandom % 8) == 0) ? 2'($urandom) : 2'd0;
    bus.cp0_epc      = $urandom;
    bus.cnt_we       = ($urandom % 60) == 0;
    bus.cnt_wdata    = $urandom % 64;
    bus.cmp_we       = ($urandom % 40) == 0;
    bus.cmp_wdata    = m_count() + ($urandom % 24);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_commit", 32'(bus.exc_commit), 32'd0);
    check("rst_new_pc", bus.new_pc, 32'd0);
    check("rst_count",  bus.count_o, 32'd0);
    clear_inputs();
    step();

    // id_sys, not in a delay slot; event held through the drain window
    bus.mem_valid = 1'b1; bus.mem_pc = 32'hBFC00100; bus.mem_exc = 7'b0001000;
    step();
    check("sys_commit", 32'(bus.exc_commit), 32'd1);
    check("sys_code",   32'(bus.exc_code),   32'h08);
    check("sys_epc",    bus.exc_epc,         32'hBFC00100);
    check("sys_flush",  32'(bus.flush),      32'd1);
    check("sys_newpc",  bus.new_pc,          32'hBFC00380);
    step(); check("sys_drain1", 32'(bus.exc_commit), 32'd0);
    step(); check("sys_drain2", 32'(bus.exc_commit), 32'd0);
    idle(D + 1);

    // ex_ov beats mem_ades in a delay slot
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h80001004; bus.mem_in_ds = 1'b1;
    bus.mem_exc = 7'b0010001; bus.mem_badvaddr = 32'h1234_5678;
    step();
    check("ov_code",  32'(bus.exc_code),  32'h0C);
    check("ov_epc",   bus.exc_epc,        32'h80001000);
    check("ov_bd",    32'(bus.exc_bd),    32'd1);
    check("ov_bvwe",  32'(bus.exc_bv_we), 32'd0);
    idle(D + 1);

    // mem_adel reports the data address
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h80000040; bus.mem_exc = 7'b0000010;
    bus.mem_badvaddr = 32'h00000003;
    step();
    check("adel_code", 32'(bus.exc_code),  32'h04);
    check("adel_bv",   bus.exc_badvaddr,   32'h00000003);
    check("adel_bvwe", 32'(bus.exc_bv_we), 32'd1);
    idle(D + 1);

    // ERET, then an exception arriving during drain is ignored
    bus.mem_valid = 1'b1; bus.mem_eret = 1'b1; bus.cp0_epc = 32'h80000200;
    step();
    check("eret_commit", 32'(bus.eret_commit), 32'd1);
    check("eret_exc",    32'(bus.exc_commit),  32'd0);
    check("eret_newpc",  bus.new_pc,           32'h80000200);
    clear_inputs();
    bus.mem_valid = 1'b1; bus.mem_exc = 7'b0000100;
    step(); check("eret_drain1", 32'(bus.exc_commit), 32'd0);
    step(); check("eret_drain2", 32'(bus.exc_commit), 32'd0);
    idle(D + 1);

`ifdef EXCEPT_TIMER_EN
    begin
      int n;
      bus.status_ie = 1'b1; bus.status_im = 8'h80;
      bus.cmp_we = 1'b1; bus.cmp_wdata = 32'd10; bus.cnt_we = 1'b1; bus.cnt_wdata = 32'd0;
      step();
      bus.cmp_we = 1'b0; bus.cnt_we = 1'b0;
      n = 0;
      while (!bus.timer_int && n < 60) begin step(); n++; end
      check("tmr_latency", 32'(n), 32'd20);
      check("tmr_count",   bus.count_o, 32'd10);
      bus.mem_valid = 1'b1; bus.mem_pc = 32'h80000100;
      step();
      check("tmr_int_code",   32'(bus.exc_code),   32'h00);
      check("tmr_int_commit", 32'(bus.exc_commit), 32'd1);
      idle(D + 1);
      bus.cmp_we = 1'b1; bus.cmp_wdata = 32'hFFFF0000;
      step();
      check("tmr_clear", 32'(bus.timer_int), 32'd0);
      idle(2);
    end
`endif

    // reset during COMMIT drops everything
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h80000300; bus.mem_exc = 7'b0100000;
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    check("rstc_flush", 32'(bus.flush),    32'd0);
    check("rstc_code",  32'(bus.exc_code), 32'd0);
    check("rstc_epc",   bus.exc_epc,       32'd0);
    clear_inputs();
    step();

    // stall hides a pending id_bp until it drops
    bus.mem_valid = 1'b1; bus.stall = 1'b1; bus.mem_pc = 32'h80000500; bus.mem_exc = 7'b0000100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 32'(bus.exc_commit), 32'd0);
    end
    bus.stall = 1'b0;
    step();
    check("stall_commit", 32'(bus.exc_commit), 32'd1);
    check("stall_code",   32'(bus.exc_code),   32'h09);
    idle(D + 1);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
